// File: rtl/spi_target_rx.sv
// SPI mode-0 target endpoint, oversampled from PCLK: deserialises MOSI into
// rx_data/rx_valid and serialises a one-entry TX buffer onto MISO.
`timescale 1ns/1ps
module spi_target_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  SCLK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [1:0] settle_cnt;
    logic       armed;

    logic [0:0]            state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  tx_buf_full;
    logic                  load;
    logic                  rx_done;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, accept;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    // A CS_N already low when reset releases must not look like a new frame,
    // so falls only count once a settled high level has been observed.
    assign cs_fall   = armed & cs_sync[2] & ~cs_sync[1];
    assign cs_rise   = ~cs_sync[2] & cs_sync[1];
    assign accept    = tx_valid & ~tx_buf_full;
    assign tx_ready  = ~tx_buf_full;
    assign busy      = (state == ACTIVE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        rx_shift_nxt = rx_shift;
        tx_shift_nxt = tx_shift;
        load         = 1'b0;
        rx_done      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt   = ACTIVE;
                    bit_cnt_nxt = '0;
                    load        = 1'b1;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_nxt    = IDLE;
                    bit_cnt_nxt  = '0;
                    rx_shift_nxt = '0;
                    tx_shift_nxt = '0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_nxt = {rx_shift[DATA_WIDTH-2:0], mosi_sync[1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_nxt = '0;
                            rx_done     = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        if (bit_cnt == '0) load = 1'b1;
                        else               tx_shift_nxt = tx_shift << 1;
                    end
                end
            end
        endcase
        if (load) tx_shift_nxt = tx_buf_full ? tx_buf : '0;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sclk_sync   <= 3'b000;
            cs_sync     <= 3'b111;
            mosi_sync   <= 2'b00;
            settle_cnt  <= 2'd0;
            armed       <= 1'b0;
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_buf_full <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            MISO        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            sclk_sync   <= {sclk_sync[1:0], SCLK};
            cs_sync     <= {cs_sync[1:0], CS_N};
            mosi_sync   <= {mosi_sync[0], MOSI};
            if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
            armed       <= armed | ((settle_cnt == 2'd3) & cs_sync[2]);
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            rx_valid    <= rx_done;
            tx_underrun <= load & ~tx_buf_full;
            MISO        <= (state_nxt == ACTIVE) ? tx_shift_nxt[DATA_WIDTH-1] : 1'b0;
            if (rx_done) rx_data <= rx_shift_nxt;
            if (accept) begin
                tx_buf      <= tx_data;
                tx_buf_full <= 1'b1;
            end else if (load) begin
                tx_buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target_rx.sv
// Self-checking bench for spi_target_rx: table-driven single frames plus
// hand-written back-to-back, underrun, abort and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_spi_target_rx;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       SCLK = 1'b0;
    logic       CS_N = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int underrun_cnt = 0;
    logic [7:0] sb_q[$];

    spi_target_rx #(.DATA_WIDTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit         preload;
        logic [7:0] tx;
        logic [7:0] rx;
        logic [7:0] exp_miso;
        int         exp_underrun;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // Scoreboard: every rx_valid pops the oldest word the controller sent.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1) begin
            if (rx_valid) begin
                if (sb_q.size() == 0) check("rx_spurious", sb_q.size(), 1);
                else check("rx_data", rx_data, sb_q.pop_front());
            end
            if (tx_underrun) underrun_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [7:0] w);
        int n = 0;
        while (!tx_ready && n < 200) begin
            cyc(1);
            n++;
        end
        if (!tx_ready) check("tx_ready_timeout", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        check("tx_ready_fall", tx_ready, 0);
    endtask

    // Controller side: half-period 6 PCLK. The frame ends by raising CS_N while
    // SCLK is still high, so the closing SCLK fall lands in IDLE.
    task automatic run_frame(input logic [15:0] mosi_w, input int nbits, input bit push_rx,
                             output logic [15:0] miso_w);
        logic [7:0] cur = 8'h00;
        miso_w = '0;
        CS_N = 1'b0;
        cyc(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_w[nbits-1-i];
            cur  = {cur[6:0], mosi_w[nbits-1-i]};
            cyc(6);
            SCLK = 1'b1;
            miso_w[nbits-1-i] = MISO;
            if (push_rx && (i % 8 == 7)) sb_q.push_back(cur);
            cyc(6);
            if (i != nbits - 1) SCLK = 1'b0;
        end
        CS_N = 1'b1;
        cyc(6);
        SCLK = 1'b0;
        cyc(6);
    endtask

    vec_t vecs[4];
    logic [15:0] m;
    int u0;

    initial begin
        vecs[0] = '{preload: 1'b1, tx: 8'h3C, rx: 8'hA5, exp_miso: 8'h3C, exp_underrun: 0};
        vecs[1] = '{preload: 1'b0, tx: 8'h00, rx: 8'h55, exp_miso: 8'h00, exp_underrun: 1};
        vecs[2] = '{preload: 1'b1, tx: 8'hFF, rx: 8'h00, exp_miso: 8'hFF, exp_underrun: 0};
        vecs[3] = '{preload: 1'b1, tx: 8'h01, rx: 8'h80, exp_miso: 8'h01, exp_underrun: 0};

        // Reset with toggling inputs.
        for (int i = 0; i < 3; i++) begin
            SCLK = ~SCLK; CS_N = ~CS_N; MOSI = ~MOSI;
            tx_valid = 1'b1; tx_data = 8'hAA;
            cyc(1);
        end
        check("rst_miso", MISO, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_underrun", tx_underrun, 0);
        tx_valid = 1'b0; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0;
        PRESETn = 1'b1;
        cyc(8);
        check("post_rst_tx_ready", tx_ready, 1);

        // Single-word frames from the table.
        foreach (vecs[k]) begin
            u0 = underrun_cnt;
            if (vecs[k].preload) preload(vecs[k].tx);
            run_frame({8'h00, vecs[k].rx}, 8, 1'b1, m);
            check("vec_miso", m[7:0], vecs[k].exp_miso);
            check("vec_underrun", underrun_cnt - u0, vecs[k].exp_underrun);
            check("vec_busy", busy, 0);
            check("vec_tx_ready", tx_ready, 1);
        end
        check("rx_hold", rx_data, 8'h80);

        // Back-to-back: second TX word accepted after the first load.
        u0 = underrun_cnt;
        preload(8'h81);
        fork
            run_frame(16'h1234, 16, 1'b1, m);
            begin
                cyc(2);
                preload(8'h7E);
            end
        join
        check("b2b_miso", m, 16'h817E);
        check("b2b_underrun", underrun_cnt - u0, 0);
        check("b2b_tx_ready", tx_ready, 1);

        // Abort after 5 SCLK rises, then a clean frame.
        u0 = underrun_cnt;
        run_frame(16'h0015, 5, 1'b0, m);
        check("abort_busy", busy, 0);
        check("abort_rx_data_held", rx_data, 8'h34);
        run_frame(16'h00C3, 8, 1'b1, m);
        check("abort_next_miso", m[7:0], 8'h00);
        check("abort_underrun", underrun_cnt - u0, 2);

        // Reset mid-frame with CS_N held low.
        CS_N = 1'b0;
        cyc(6);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'b1; cyc(6); SCLK = 1'b1; cyc(6); SCLK = 1'b0;
        end
        check("mid_busy_before", busy, 1);
        PRESETn = 1'b0;
        cyc(3);
        PRESETn = 1'b1;
        cyc(6);
        check("mid_busy_after", busy, 0);
        check("mid_miso", MISO, 0);
        check("mid_rx_data", rx_data, 0);
        for (int i = 0; i < 10; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            cyc(6); SCLK = 1'b1; cyc(6); SCLK = 1'b0;
        end
        check("mid_ignored_busy", busy, 0);
        CS_N = 1'b1;
        cyc(8);
        preload(8'hE7);
        run_frame(16'h005A, 8, 1'b1, m);
        check("mid_next_miso", m[7:0], 8'hE7);

        cyc(20);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
